spi_slave_rx: RTL

Receive-side SPI endpoint that deserializes frames produced by the team's SPI master: chip-select active-low, data LSB first, master updates `mosi` on `sclk` rising edges. The block oversamples `sclk`, `cs` and `mosi` in the system `clk` domain, captures `DW` bits per frame and presents the parallel word with a one-cycle `done` strobe. It also flags short and overlong frames.

---
 rtl/spi_slave_rx_if.sv | 23 ++
 rtl/spi_slave_rx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_if.sv
// Bus bundle for the SPI receive endpoint: the serial pins from the master
// and the parallel word and status strobes returned by the receiver.
interface spi_slave_rx_if #(
    parameter int DW = 12
);
    logic          sclk;
    logic          cs;
    logic          mosi;
    logic [DW-1:0] dout;
    logic          done;
    logic          busy;
    logic          frame_err;

    modport master (
        output sclk, cs, mosi,
        input  dout, done, busy, frame_err
    );

    modport slave (
        input  sclk, cs, mosi,
        output dout, done, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI receive endpoint: oversamples sclk/cs/mosi in the clk domain,
// deserializes LSB-first DW-bit frames and flags short or overlong frames.
module spi_slave_rx #(
    parameter int DW          = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_slave_rx_if.slave bus
);
    localparam int CW = $clog2(DW + 1);
    localparam int SW = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        RECV      = 2'd2,
        HOLD      = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
    logic                   sclk_hist_r, cs_hist_r;
    logic [SW-1:0]          settle_r;
    state_t                 state_r, state_s;
    logic [CW-1:0]          count_r, count_s;
    logic [DW-1:0]          shift_r, shift_s;
    logic [DW-1:0]          dout_r, dout_s;
    logic                   armed_r, armed_s;
    logic                   ovf_r, ovf_s;
    logic                   done_r, done_s;
    logic                   frame_err_r, frame_err_s;
    logic                   busy_r;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s        = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_hist_r;
    assign sclk_fall_s = ~sclk_s & sclk_hist_r;
    assign cs_fall_s   = ~cs_s & cs_hist_r;
    assign cs_rise_s   = cs_s & ~cs_hist_r;

    // Input synchronizers (SYNC_STAGES >= 2) plus edge-detect history flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_r <= '0;
            cs_sync_r   <= '1;
            mosi_sync_r <= '0;
            sclk_hist_r <= 1'b0;
            cs_hist_r   <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.cs};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi};
            sclk_hist_r <= sclk_s;
            cs_hist_r   <= cs_s;
        end
    end

    // Post-reset settle counter: the synchronizer reset value of cs is high,
    // so WAIT_HIGH must not trust it until the chain holds real pin samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_r <= '0;
        end else if (settle_r != SETTLE) begin
            settle_r <= settle_r + SW'(1);
        end else begin
            settle_r <= settle_r;
        end
    end

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        shift_s     = shift_r;
        armed_s     = armed_r;
        ovf_s       = ovf_r;
        dout_s      = dout_r;
        done_s      = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            WAIT_HIGH: begin
                if ((settle_r == SETTLE) && cs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_HIGH;
                end
            end
            IDLE: begin
                if (cs_fall_s) begin
                    state_s = RECV;
                    count_s = '0;
                    shift_s = '0;
                    armed_s = 1'b0;
                    ovf_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RECV: begin
                // cs rise has priority over a coincident sclk fall.
                if (cs_rise_s) begin
                    frame_err_s = 1'b1;
                    state_s     = IDLE;
                end else if (sclk_fall_s && armed_r) begin
                    shift_s = {mosi_s, shift_r[DW-1:1]};
                    if (count_r == CW'(DW - 1)) begin
                        count_s = CW'(DW);
                        dout_s  = {mosi_s, shift_r[DW-1:1]};
                        done_s  = 1'b1;
                        state_s = HOLD;
                    end else begin
                        count_s = count_r + CW'(1);
                    end
                end else if (sclk_rise_s) begin
                    armed_s = 1'b1;
                end else begin
                    armed_s = armed_r;
                end
            end
            HOLD: begin
                if (cs_rise_s) begin
                    frame_err_s = ovf_r;
                    state_s     = IDLE;
                end else if (sclk_fall_s) begin
                    ovf_s = 1'b1;
                end else begin
                    ovf_s = ovf_r;
                end
            end
            default: begin
                state_s = WAIT_HIGH;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= WAIT_HIGH;
            count_r     <= '0;
            shift_r     <= '0;
            armed_r     <= 1'b0;
            ovf_r       <= 1'b0;
            dout_r      <= '0;
            done_r      <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            shift_r     <= shift_s;
            armed_r     <= armed_s;
            ovf_r       <= ovf_s;
            dout_r      <= dout_s;
            done_r      <= done_s;
            frame_err_r <= frame_err_s;
            busy_r      <= (state_s == RECV) || (state_s == HOLD);
        end
    end

    assign bus.dout      = dout_r;
    assign bus.done      = done_r;
    assign bus.busy      = busy_r;
    assign bus.frame_err = frame_err_r;
endmodule
